// File: rtl/acc_stream_core_if.sv
// acc_stream_core_if: sample, result, length and config bus bundle for acc_stream_core.
// slave modport is the core side, master modport is the driving side.
interface acc_stream_core_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned LEN_W  = 8
);
    logic [DATA_W-1:0] din_value;
    logic              din_en;
    logic              din_rdy;

    logic              dout_en;
    logic [DATA_W-1:0] dout_value;
    logic              dout_rdy;

    logic [LEN_W-1:0]  len_value;
    logic              len_en;
    logic              len_rdy;

    logic [7:0]        cfg_address;
    logic [31:0]       cfg_data_in;
    logic              cfg_op;
    logic              cfg_en;
    logic [31:0]       cfg_data_out;
    logic              cfg_rdy;

    modport slave (
        input  din_value, din_en, dout_en, len_value, len_en,
               cfg_address, cfg_data_in, cfg_op, cfg_en,
        output din_rdy, dout_value, dout_rdy, len_rdy, cfg_data_out, cfg_rdy
    );

    modport master (
        output din_value, din_en, dout_en, len_value, len_en,
               cfg_address, cfg_data_in, cfg_op, cfg_en,
        input  din_rdy, dout_value, dout_rdy, len_rdy, cfg_data_out, cfg_rdy
    );
endinterface

// File: rtl/acc_stream_core.sv
// acc_stream_core: frame accumulator. Takes a frame length, sums that many
// samples (signed/unsigned, wrap/saturate), pushes each frame sum into an
// output FIFO. Registers: CTRL 0x00, STATUS 0x04, FRAMES 0x08.
// Optional macro ACC_OVF_IRQ_EN adds the ovf_irq output and CTRL bit3 mask.
module acc_stream_core #(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned LEN_W      = 8,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic CLK,
    input  logic RST,
`ifdef ACC_OVF_IRQ_EN
    output logic ovf_irq,
`endif
    acc_stream_core_if.slave bus
);

    localparam int unsigned   PTR_W    = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0] FILL_MAX = (PTR_W + 1)'(FIFO_DEPTH);
    localparam logic [PTR_W:0] FILL_ONE = (PTR_W + 1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
    localparam logic [LEN_W-1:0] CNT_ONE = LEN_W'(1);
`ifdef ACC_OVF_IRQ_EN
    localparam logic [3:0]    CTRL_MASK = 4'hF;
`else
    localparam logic [3:0]    CTRL_MASK = 4'h7;
`endif

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    state_t            state_q, state_d;

    logic [3:0]        ctrl_q;
    logic              mode_signed_q;
    logic              mode_sat_q;
    logic [DATA_W-1:0] sum_q;
    logic [LEN_W-1:0]  count_q;
    logic              ovf_q;
    logic [31:0]       frames_q;

    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]    fill_q;

    logic              fifo_empty, fifo_full;
    logic              len_rdy, din_rdy, busy;
    logic              len_fire, len_load, din_fire, last_fire;
    logic              push, pop;
    logic              cfg_wr;

    logic [DATA_W:0]   sum_ext;
    logic [DATA_W-1:0] add_raw;
    logic [DATA_W-1:0] sum_next;
    logic              add_ovf;
    logic              signed_ovf;

    logic [31:0]       status_word;
    logic [31:0]       cfg_rdata;
    logic              unused_cfg_bits;

    assign fifo_empty = (fill_q == '0);
    assign fifo_full  = (fill_q == FILL_MAX);

    assign len_fire  = bus.len_en & len_rdy;
    assign len_load  = len_fire & (bus.len_value != '0);
    assign din_fire  = bus.din_en & din_rdy;
    assign last_fire = din_fire & (count_q == CNT_ONE);
    assign push      = last_fire;
    assign pop       = bus.dout_en & ~fifo_empty;
    assign cfg_wr    = bus.cfg_en & bus.cfg_op;

    assign unused_cfg_bits = ^bus.cfg_data_in[31:4];

    // State register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: a non-zero length starts a frame, the last sample ends it
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (len_load)  state_d = BUSY;
            BUSY: if (last_fire) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Handshake outputs; the last sample stalls while the FIFO has no room for its sum
    always_comb begin
        len_rdy = 1'b0;
        din_rdy = 1'b0;
        busy    = 1'b0;
        unique case (state_q)
            IDLE: len_rdy = 1'b1;
            BUSY: begin
                busy    = 1'b1;
                din_rdy = ~ctrl_q[0] & ~((count_q == CNT_ONE) & fifo_full);
            end
            default: ;
        endcase
    end

    // DATA_W+1 bit add with overflow detection and optional clamping
    always_comb begin
        sum_ext    = {1'b0, sum_q} + {1'b0, bus.din_value};
        add_raw    = sum_ext[DATA_W-1:0];
        signed_ovf = (sum_q[DATA_W-1] == bus.din_value[DATA_W-1]) &&
                     (add_raw[DATA_W-1] != sum_q[DATA_W-1]);
        add_ovf    = mode_signed_q ? signed_ovf : sum_ext[DATA_W];
        sum_next   = add_raw;
        if (add_ovf && mode_sat_q) begin
            if (!mode_signed_q) begin
                sum_next = '1;
            end else if (sum_q[DATA_W-1]) begin
                sum_next = {1'b1, {(DATA_W-1){1'b0}}};
            end else begin
                sum_next = {1'b0, {(DATA_W-1){1'b1}}};
            end
        end
    end

    // Frame datapath: load on length, accumulate on each accepted sample
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sum_q         <= '0;
            count_q       <= '0;
            mode_signed_q <= 1'b0;
            mode_sat_q    <= 1'b0;
        end else if (len_load) begin
            sum_q         <= '0;
            count_q       <= bus.len_value;
            mode_signed_q <= ctrl_q[1];
            mode_sat_q    <= ctrl_q[2];
        end else if (din_fire) begin
            sum_q   <= sum_next;
            count_q <= count_q - CNT_ONE;
        end
    end

    // Control register and sticky overflow; a new overflow beats a same-cycle clear
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ctrl_q <= '0;
            ovf_q  <= 1'b0;
        end else begin
            if (cfg_wr && bus.cfg_address == 8'h00) begin
                ctrl_q <= bus.cfg_data_in[3:0] & CTRL_MASK;
            end
            if (din_fire && add_ovf) begin
                ovf_q <= 1'b1;
            end else if (cfg_wr && bus.cfg_address == 8'h04 && bus.cfg_data_in[1]) begin
                ovf_q <= 1'b0;
            end
        end
    end

    // Completed-frame counter
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            frames_q <= '0;
        end else if (push) begin
            frames_q <= frames_q + 32'd1;
        end
    end

    // FIFO pointers and occupancy; push and pop together leave the fill unchanged
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            fill_q   <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
            unique case ({push, pop})
                2'b10:   fill_q <= fill_q + FILL_ONE;
                2'b01:   fill_q <= fill_q - FILL_ONE;
                default: fill_q <= fill_q;
            endcase
        end
    end

    // FIFO storage; the final sum is written in the cycle it is computed
    always_ff @(posedge CLK) begin
        if (push) begin
            mem_q[wr_ptr_q] <= sum_next;
        end
    end

`ifdef ACC_OVF_IRQ_EN
    // Masked overflow interrupt, one cycle behind ovf
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ovf_irq <= 1'b0;
        end else begin
            ovf_irq <= ovf_q & ctrl_q[3];
        end
    end
`endif

    // Register read mux, combinational from the address
    always_comb begin
        status_word              = '0;
        status_word[0]           = busy;
        status_word[1]           = ovf_q;
        status_word[8 +: LEN_W]  = count_q;
        unique case (bus.cfg_address)
            8'h00:   cfg_rdata = {28'd0, ctrl_q};
            8'h04:   cfg_rdata = status_word;
            8'h08:   cfg_rdata = frames_q;
            default: cfg_rdata = '0;
        endcase
    end

    assign bus.din_rdy      = din_rdy;
    assign bus.len_rdy      = len_rdy;
    assign bus.dout_rdy     = ~fifo_empty;
    assign bus.dout_value   = fifo_empty ? '0 : mem_q[rd_ptr_q];
    assign bus.cfg_data_out = cfg_rdata;
    assign bus.cfg_rdy      = 1'b1;

endmodule

// File: tb/tb_acc_stream_core.sv
// tb_acc_stream_core: table-driven frame vectors plus directed sequences for
// FIFO back-pressure, pause, mode snapshot, len=0 and mid-frame reset.
module tb_acc_stream_core;

    localparam int unsigned DATA_W     = 8;
    localparam int unsigned LEN_W      = 8;
    localparam int unsigned FIFO_DEPTH = 4;
`ifdef ACC_OVF_IRQ_EN
    localparam logic [31:0] CTRL_RB = 32'hF;
`else
    localparam logic [31:0] CTRL_RB = 32'h7;
`endif

    logic CLK = 1'b0;
    logic RST;
    always #5 CLK = ~CLK;

    acc_stream_core_if #(.DATA_W(DATA_W), .LEN_W(LEN_W)) bus ();
`ifdef ACC_OVF_IRQ_EN
    logic ovf_irq;
`endif

    acc_stream_core #(
        .DATA_W(DATA_W),
        .LEN_W(LEN_W),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .CLK(CLK),
        .RST(RST),
`ifdef ACC_OVF_IRQ_EN
        .ovf_irq(ovf_irq),
`endif
        .bus(bus)
    );

    typedef struct {
        logic [3:0]  ctrl;
        int unsigned len;
        logic [7:0]  s0, s1, s2;
        logic [7:0]  exp_sum;
        logic        exp_ovf;
    } vec_t;

    int unsigned pass_cnt = 0;
    int unsigned total_cnt = 0;
    int unsigned exp_frames = 0;
    logic [31:0] rd;

    function automatic vec_t mk(input logic [3:0] c, input int unsigned l,
                                input logic [7:0] a, input logic [7:0] b, input logic [7:0] d,
                                input logic [7:0] e, input logic o);
        vec_t v;
        v.ctrl = c; v.len = l; v.s0 = a; v.s1 = b; v.s2 = d;
        v.exp_sum = e; v.exp_ovf = o;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic cfg_write(input logic [7:0] addr, input logic [31:0] data);
        bus.cfg_address = addr;
        bus.cfg_data_in = data;
        bus.cfg_op      = 1'b1;
        bus.cfg_en      = 1'b1;
        tick();
        bus.cfg_en      = 1'b0;
        bus.cfg_op      = 1'b0;
    endtask

    task automatic cfg_read(input logic [7:0] addr, output logic [31:0] d);
        bus.cfg_address = addr;
        bus.cfg_op      = 1'b0;
        #1;
        d = bus.cfg_data_out;
    endtask

    task automatic send_len(input logic [7:0] l);
        int unsigned waited = 0;
        while (!bus.len_rdy && waited < 50) begin
            tick();
            waited++;
        end
        if (!bus.len_rdy) begin
            check("len_rdy_timeout", {31'd0, bus.len_rdy}, 32'd1);
        end else begin
            bus.len_value = l;
            bus.len_en    = 1'b1;
            tick();
            bus.len_en    = 1'b0;
        end
    endtask

    task automatic send_sample(input logic [7:0] v);
        int unsigned waited = 0;
        while (!bus.din_rdy && waited < 50) begin
            tick();
            waited++;
        end
        if (!bus.din_rdy) begin
            check("din_rdy_timeout", {31'd0, bus.din_rdy}, 32'd1);
        end else begin
            bus.din_value = v;
            bus.din_en    = 1'b1;
            tick();
            bus.din_en    = 1'b0;
        end
    endtask

    task automatic pop();
        bus.dout_en = 1'b1;
        tick();
        bus.dout_en = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs [10];
        logic [7:0] smp;

        vecs[0] = mk(4'h0, 3, 8'd10,  8'd20,  8'd30, 8'd60,  1'b0);
        vecs[1] = mk(4'h4, 2, 8'd200, 8'd100, 8'd0,  8'd255, 1'b1);
        vecs[2] = mk(4'h6, 2, 8'h90,  8'h90,  8'h0,  8'h80,  1'b1);
        vecs[3] = mk(4'h2, 2, 8'h90,  8'h90,  8'h0,  8'h20,  1'b1);
        vecs[4] = mk(4'h0, 2, 8'd200, 8'd100, 8'd0,  8'h2C,  1'b1);
        vecs[5] = mk(4'h6, 2, 8'h70,  8'h70,  8'h0,  8'h7F,  1'b1);
        vecs[6] = mk(4'h2, 2, 8'h05,  8'hFD,  8'h0,  8'h02,  1'b0);
        vecs[7] = mk(4'h6, 2, 8'h7F,  8'h80,  8'h0,  8'hFF,  1'b0);
        vecs[8] = mk(4'h4, 3, 8'd200, 8'd100, 8'd10, 8'd255, 1'b1);
        vecs[9] = mk(4'h0, 1, 8'hAB,  8'h00,  8'h00, 8'hAB,  1'b0);

        bus.din_value = '0; bus.din_en = 1'b0; bus.dout_en = 1'b0;
        bus.len_value = '0; bus.len_en = 1'b0;
        bus.cfg_address = '0; bus.cfg_data_in = '0; bus.cfg_op = 1'b0; bus.cfg_en = 1'b0;
        RST = 1'b1;
        tick(); tick();
        RST = 1'b0;
        tick();

        // Reset state
        check("rst_len_rdy",    {31'd0, bus.len_rdy},  32'd1);
        check("rst_din_rdy",    {31'd0, bus.din_rdy},  32'd0);
        check("rst_dout_rdy",   {31'd0, bus.dout_rdy}, 32'd0);
        check("rst_dout_value", {24'd0, bus.dout_value}, 32'd0);
        check("rst_cfg_rdy",    {31'd0, bus.cfg_rdy},  32'd1);
        cfg_read(8'h00, rd); check("rst_ctrl", rd, 32'd0);
        cfg_read(8'h04, rd); check("rst_status", rd, 32'd0);
        cfg_read(8'h08, rd); check("rst_frames", rd, 32'd0);

        // Table-driven frames
        for (int i = 0; i < 10; i++) begin
            cfg_write(8'h00, {28'd0, vecs[i].ctrl});
            cfg_write(8'h04, 32'h2);
            send_len(8'(vecs[i].len));
            check($sformatf("v%0d_len_rdy_busy", i), {31'd0, bus.len_rdy}, 32'd0);
            for (int k = 0; k < int'(vecs[i].len); k++) begin
                case (k)
                    0:       smp = vecs[i].s0;
                    1:       smp = vecs[i].s1;
                    default: smp = vecs[i].s2;
                endcase
                if (k == int'(vecs[i].len) - 1)
                    check($sformatf("v%0d_dout_rdy_early", i), {31'd0, bus.dout_rdy}, 32'd0);
                send_sample(smp);
            end
            exp_frames++;
            check($sformatf("v%0d_dout_rdy", i), {31'd0, bus.dout_rdy}, 32'd1);
            check($sformatf("v%0d_sum", i), {24'd0, bus.dout_value}, {24'd0, vecs[i].exp_sum});
            tick();
            check($sformatf("v%0d_len_rdy_after", i), {31'd0, bus.len_rdy}, 32'd1);
            cfg_read(8'h04, rd);
            check($sformatf("v%0d_ovf", i), {31'd0, rd[1]}, {31'd0, vecs[i].exp_ovf});
            cfg_read(8'h08, rd);
            check($sformatf("v%0d_frames", i), rd, exp_frames);
            pop();
            check($sformatf("v%0d_dout_empty", i), {31'd0, bus.dout_rdy}, 32'd0);
        end

        // W1C of ovf after a saturating frame, then mode snapshot across a CTRL change
        cfg_write(8'h00, 32'h4);
        send_len(8'd2);
        send_sample(8'd200);
        cfg_write(8'h00, 32'h0);
        send_sample(8'd100);
        exp_frames++;
        check("snap_sum", {24'd0, bus.dout_value}, 32'd255);
        cfg_read(8'h04, rd); check("snap_ovf_set", rd, 32'h2);
        cfg_write(8'h04, 32'h2);
        cfg_read(8'h04, rd); check("w1c_ovf_clear", rd, 32'h0);
        pop();

        // FIFO full back-pressure, then simultaneous push and pop
        cfg_write(8'h00, 32'h0);
        for (int j = 1; j <= 4; j++) begin
            send_len(8'(j));
            for (int k = 0; k < j; k++) send_sample((k == 0) ? 8'(j) : 8'd0);
        end
        exp_frames += 4;
        check("full_head", {24'd0, bus.dout_value}, 32'd1);
        send_len(8'd1);
        check("full_din_rdy", {31'd0, bus.din_rdy}, 32'd0);
        bus.din_value = 8'd9; bus.din_en = 1'b1;
        tick();
        bus.din_en = 1'b0;
        cfg_read(8'h04, rd); check("full_status", rd, 32'h101);
        pop();
        check("full_din_rdy_after_pop", {31'd0, bus.din_rdy}, 32'd1);
        check("full_head2", {24'd0, bus.dout_value}, 32'd2);
        bus.dout_en = 1'b1;
        send_sample(8'd5);
        bus.dout_en = 1'b0;
        exp_frames++;
        for (int j = 3; j <= 5; j++) begin
            check($sformatf("drain_%0d", j), {24'd0, bus.dout_value}, 32'(j));
            pop();
        end
        check("drain_empty", {31'd0, bus.dout_rdy}, 32'd0);
        cfg_read(8'h08, rd); check("drain_frames", rd, exp_frames);

        // Pause mid-frame
        send_len(8'd4);
        send_sample(8'd1);
        send_sample(8'd2);
        cfg_write(8'h00, 32'h1);
        check("pause_din_rdy", {31'd0, bus.din_rdy}, 32'd0);
        cfg_read(8'h04, rd); check("pause_status", rd, 32'h201);
        bus.din_value = 8'd99; bus.din_en = 1'b1;
        tick(); tick();
        bus.din_en = 1'b0;
        cfg_read(8'h04, rd); check("pause_status_hold", rd, 32'h201);
        cfg_write(8'h00, 32'h0);
        send_sample(8'd3);
        send_sample(8'd4);
        exp_frames++;
        check("pause_sum", {24'd0, bus.dout_value}, 32'd10);
        pop();

        // CTRL bit3 availability, unmapped and read-only addresses
        cfg_write(8'h00, 32'hF);
        cfg_read(8'h00, rd); check("ctrl_readback", rd, CTRL_RB);
        cfg_write(8'h00, 32'h0);
        cfg_write(8'h10, 32'hFFFF_FFFF);
        cfg_read(8'h10, rd); check("unmapped_read", rd, 32'd0);
        cfg_write(8'h08, 32'd0);
        cfg_read(8'h08, rd); check("frames_ro", rd, exp_frames);

        // len=0 is accepted without producing a frame
        send_len(8'd0);
        check("len0_len_rdy", {31'd0, bus.len_rdy}, 32'd1);
        check("len0_dout_rdy", {31'd0, bus.dout_rdy}, 32'd0);
        cfg_read(8'h04, rd); check("len0_status", rd, 32'd0);
        cfg_read(8'h08, rd); check("len0_frames", rd, exp_frames);

        // Reset mid-frame with a sum waiting in the FIFO
        send_len(8'd1);
        send_sample(8'd7);
        send_len(8'd3);
        send_sample(8'd5);
        cfg_read(8'h04, rd); check("pre_rst_status", rd, 32'h201);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        tick();
        check("mid_rst_len_rdy",    {31'd0, bus.len_rdy},  32'd1);
        check("mid_rst_din_rdy",    {31'd0, bus.din_rdy},  32'd0);
        check("mid_rst_dout_rdy",   {31'd0, bus.dout_rdy}, 32'd0);
        check("mid_rst_dout_value", {24'd0, bus.dout_value}, 32'd0);
        cfg_read(8'h04, rd); check("mid_rst_status", rd, 32'd0);
        cfg_read(8'h08, rd); check("mid_rst_frames", rd, 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
